// File: rtl/m_scope_pkg.sv
// Shared encodings for the scope trigger path: trigger modes and trigger FSM states.
package m_scope_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } trig_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HOLDOFF
  } trig_state_e;

endpackage

// File: rtl/m_delay_line.sv
// Enabled sample shift register with async clear, head/tail taps and a saturating fill flag.
module m_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail,
  output logic             filled
);

  localparam int unsigned FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [FW-1:0]    fill_q, fill_d;

  always_comb begin
    d_d    = d_q;
    fill_d = fill_q;
    if (en) begin
      d_d[0] = din;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        d_d[k] = d_q[k-1];
      end
      if (fill_q != FW'(DEPTH)) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
      fill_q <= '0;
    end else begin
      d_q    <= d_d;
      fill_q <= fill_d;
    end
  end

  assign head   = d_q[0];
  assign tail   = d_q[DEPTH-1];
  assign filled = (fill_q == FW'(DEPTH));

endmodule

// File: rtl/m_slope_trigger.sv
// Slope trigger: compares each sample with the one SPAN samples earlier and fires a
// one-cycle trigger pulse, with arming, mode select and a holdoff counted in samples.
module m_slope_trigger
  import m_scope_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SPAN   = 1,
  parameter int unsigned HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  pos_level,
  input  logic [WIDTH-1:0]  neg_level,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              arm,
  input  logic              auto_rearm,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH:0]    delta,
  output logic              positive,
  output logic              negative,
  output logic              trig,
  output logic              armed,
  output logic              busy
);

  logic [WIDTH-1:0] head, tail;
  logic             filled;
  logic [WIDTH:0]   neg_mag;
  logic             tick_q;
  logic             hit;
  trig_mode_e       mode_e;

  trig_state_e       state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              trig_q, trig_d;
  logic              armed_q, busy_q;

  m_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (SPAN + 1)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_valid),
    .din    (in),
    .head   (head),
    .tail   (tail),
    .filled (filled)
  );

  assign mode_e   = trig_mode_e'(mode);
  assign delta    = {1'b0, head} - {1'b0, tail};
  assign neg_mag  = -delta;
  assign positive = filled & ~delta[WIDTH] & (delta[WIDTH-1:0] > pos_level);
  assign negative = filled &  delta[WIDTH] & (neg_mag > {1'b0, neg_level});
  assign out      = tail;

  // tick_q marks the single cycle in which the newest sample's flags are evaluated
  assign hit = tick_q & ((mode[0] & positive) | (mode[1] & negative));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    if (mode_e == MODE_OFF) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (hit) begin
            trig_d = 1'b1;
            if (holdoff != '0) begin
              state_d = ST_HOLDOFF;
              cnt_d   = holdoff;
            end else begin
              state_d = auto_rearm ? ST_ARMED : ST_IDLE;
            end
          end
        end
        ST_HOLDOFF: begin
          if (tick_q) begin
            cnt_d = cnt_q - HOLD_W'(1);
            if (cnt_q <= HOLD_W'(1)) begin
              cnt_d   = '0;
              state_d = auto_rearm ? ST_ARMED : ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tick_q  <= in_valid;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      armed_q <= (state_d == ST_ARMED);
      busy_q  <= (state_d == ST_HOLDOFF);
    end
  end

  assign trig  = trig_q;
  assign armed = armed_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_m_slope_trigger.sv
// Bench for m_slope_trigger: SPAN=1 and SPAN=4 instances share stimulus and are checked
// every cycle against a sample-history model, plus hand-computed directed checks.
module tb_m_slope_trigger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_s = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  pos_level = 8'd10;
  logic [7:0]  neg_level = 8'd10;
  logic [15:0] holdoff = '0;
  logic        arm = 1'b0;
  logic        auto_rearm = 1'b0;

  logic [7:0] o1, o4;
  logic [8:0] dl1, dl4;
  logic       p1, n1, t1, a1, b1;
  logic       p4, n4, t4, a4, b4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  m_slope_trigger #(.WIDTH(8), .SPAN(1), .HOLD_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(in_s), .in_valid(in_valid), .mode(mode),
    .pos_level(pos_level), .neg_level(neg_level), .holdoff(holdoff), .arm(arm),
    .auto_rearm(auto_rearm), .out(o1), .delta(dl1), .positive(p1), .negative(n1),
    .trig(t1), .armed(a1), .busy(b1)
  );

  m_slope_trigger #(.WIDTH(8), .SPAN(4), .HOLD_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in(in_s), .in_valid(in_valid), .mode(mode),
    .pos_level(pos_level), .neg_level(neg_level), .holdoff(holdoff), .arm(arm),
    .auto_rearm(auto_rearm), .out(o4), .delta(dl4), .positive(p4), .negative(n4),
    .trig(t4), .armed(a4), .busy(b4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: per instance, a sample history (newest first), trigger permission and holdoff left.
  logic [7:0] m_hist [2][17];
  int  m_fill [2];
  bit  m_tick [2];
  bit  m_trig [2];
  bit  m_active [2];
  int  m_hold [2];

  function automatic int span_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int m_delta(input int i);
    return int'(m_hist[i][0]) - int'(m_hist[i][span_of(i)]);
  endfunction

  function automatic bit m_filled(input int i);
    return m_fill[i] >= span_of(i) + 1;
  endfunction

  function automatic bit m_pos(input int i);
    return m_filled(i) && (m_delta(i) > int'(pos_level));
  endfunction

  function automatic bit m_neg(input int i);
    return m_filled(i) && (-m_delta(i) > int'(neg_level));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 17; k++) m_hist[i][k] = '0;
      m_fill[i] = 0; m_tick[i] = 0; m_trig[i] = 0; m_active[i] = 0; m_hold[i] = 0;
    end
  endtask

  task automatic m_step();
    for (int i = 0; i < 2; i++) begin
      bit hit;
      bit nt;
      hit = m_tick[i] && ((mode[0] && m_pos(i)) || (mode[1] && m_neg(i)));
      nt = 0;
      if (mode == 2'b00) begin
        m_active[i] = 0;
        m_hold[i] = 0;
      end else if (!m_active[i]) begin
        if (arm) m_active[i] = 1;
      end else if (m_hold[i] == 0) begin
        if (hit) begin
          nt = 1;
          if (holdoff != 0) m_hold[i] = int'(holdoff);
          else if (!auto_rearm) m_active[i] = 0;
        end
      end else if (m_tick[i]) begin
        m_hold[i]--;
        if (m_hold[i] == 0 && !auto_rearm) m_active[i] = 0;
      end
      m_trig[i] = nt;
      m_tick[i] = in_valid;
      if (in_valid) begin
        for (int k = 16; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = in_s;
        if (m_fill[i] < span_of(i) + 1) m_fill[i]++;
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [7:0] o, input logic [8:0] dl,
                          input logic p, input logic n, input logic t,
                          input logic a, input logic b);
    logic [8:0] ed;
    ed = 9'(m_delta(i));
    chk($sformatf("u%0d.out", i), o, m_hist[i][span_of(i)]);
    chk($sformatf("u%0d.delta", i), dl, ed);
    chk($sformatf("u%0d.positive", i), p, m_pos(i));
    chk($sformatf("u%0d.negative", i), n, m_neg(i));
    chk($sformatf("u%0d.trig", i), t, m_trig[i]);
    chk($sformatf("u%0d.armed", i), a, m_active[i] && m_hold[i] == 0);
    chk($sformatf("u%0d.busy", i), b, m_hold[i] > 0);
  endtask

  initial m_reset();

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (!rst_n) m_reset();
    cmp_inst(0, o1, dl1, p1, n1, t1, a1, b1);
    cmp_inst(1, o4, dl4, p4, n4, t4, a4, b4);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v, input logic val);
    in_s = v;
    in_valid = val;
    cyc();
  endtask

  task automatic arm_pulse();
    in_valid = 1'b0;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  int ntrig;
  int nbusy;
  logic [7:0] gap_vals [4];

  initial begin
    repeat (3) cyc();
    chk("rst.trig", t1, 0);
    chk("rst.armed", a1, 0);
    chk("rst.busy", b1, 0);
    chk("rst.delta", dl1, 0);
    chk("rst.out", o1, 0);
    rst_n = 1'b1;
    cyc();

    mode = 2'b01;
    arm_pulse();
    chk("arm.armed", a1, 1);
    drive(8'd20, 1); drive(8'd20, 1); drive(8'd35, 1);
    chk("rise.delta", dl1, 9'd15);
    chk("rise.out", o1, 8'd20);
    chk("rise.pos", p1, 1);
    chk("rise.trig_early", t1, 0);
    chk("rise.u4_unfilled", p4, 0);
    drive(8'd0, 0);
    chk("rise.trig", t1, 1);
    drive(8'd0, 0);
    chk("rise.trig_once", t1, 0);
    chk("rise.disarmed", a1, 0);

    mode = 2'b10;
    arm_pulse();
    drive(8'd35, 1); drive(8'd20, 1);
    chk("fall.delta", dl1, 9'h1F1);
    chk("fall.neg", n1, 1);
    drive(8'd0, 0);
    chk("fall.trig", t1, 1);

    mode = 2'b01;
    arm_pulse();
    drive(8'd5, 1);
    chk("rmode.neg", n1, 1);
    drive(8'd0, 0);
    chk("rmode.notrig", t1, 0);
    chk("rmode.armed", a1, 1);

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    mode = 2'b01;
    pos_level = 8'd11;
    arm_pulse();
    for (int k = 0; k < 5; k++) begin
      drive(8'(3 * k), 1);
      if (k < 4) chk("span.unfilled", p4, 0);
    end
    chk("span.delta", dl4, 9'd12);
    chk("span.pos11", p4, 1);
    pos_level = 8'd12;
    #1;
    chk("span.pos12", p4, 0);
    drive(8'd15, 1);
    pos_level = 8'd11;
    holdoff = 16'd3;
    auto_rearm = 1'b1;
    ntrig = 0;
    nbusy = 0;
    for (int j = 0; j < 12; j++) begin
      drive(8'(18 + 3 * j), 1);
      ntrig += int'(t4);
      nbusy += int'(b4);
    end
    chk("hold.trigs", ntrig, 3);
    chk("hold.busy", nbusy, 9);

    mode = 2'b00;
    drive(8'd0, 1);
    mode = 2'b11;
    holdoff = '0;
    auto_rearm = 1'b1;
    pos_level = 8'd10;
    neg_level = 8'd10;
    arm_pulse();
    gap_vals[0] = 8'd100; gap_vals[1] = 8'd0; gap_vals[2] = 8'd100; gap_vals[3] = 8'd0;
    ntrig = 0;
    for (int g = 0; g < 4; g++) begin
      drive(gap_vals[g], 1);
      for (int q = 0; q < 5; q++) begin
        drive(gap_vals[g], 0);
        ntrig += int'(t1);
      end
    end
    chk("gap.trigs", ntrig, 4);
    drive(8'hFF, 1);
    chk("wrap.up", dl1, 9'h0FF);
    drive(8'h00, 1);
    chk("wrap.down", dl1, 9'h101);

    mode = 2'b00;
    arm = 1'b1;
    drive(8'd0, 0);
    arm = 1'b0;
    chk("off.trig", t1, 0);
    chk("off.armed", a1, 0);

    mode = 2'b11;
    holdoff = 16'd100;
    auto_rearm = 1'b0;
    arm_pulse();
    drive(8'd200, 1);
    drive(8'd0, 0);
    chk("abort.trig", t1, 1);
    chk("abort.busy_before", b1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", b1, 0);
    chk("abort.armed", a1, 0);
    chk("abort.u4_busy", b4, 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
